// File: rtl/multi_freq_counter.sv
// rtl/multi_freq_counter.sv - multi-channel gated edge counter with one-shot and continuous windows
module multi_freq_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int GATE_WIDTH  = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           sig_i,
  input  logic [GATE_WIDTH-1:0]       gate_period_i,
  input  logic                        mode_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  output logic                        busy_o,
  output logic                        result_valid_o,
  output logic [NUM_CH*CNT_WIDTH-1:0] results_o,
  output logic [NUM_CH-1:0]           overflow_o
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GATE_WIDTH-1:0] GATE_ONE = {{(GATE_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [NUM_CH-1:0]     sync_q [SS];
  logic [NUM_CH-1:0]     prev_q;
  logic [NUM_CH-1:0]     edge_det;
  logic [GATE_WIDTH-1:0] gate_q;
  logic [GATE_WIDTH-1:0] timer_q;
  logic                  mode_q;
  logic [CNT_WIDTH-1:0]  cnt_q    [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_next [NUM_CH];
  logic [NUM_CH-1:0]     ovf_q;
  logic [NUM_CH-1:0]     ovf_next;
  logic                  last_cycle;

  // Synchroniser chain and prev register run in every state so edges are never stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SS; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= sig_i;
      for (int s = 1; s < SS; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SS-1];
    end
  end

  assign edge_det   = sync_q[SS-1] & ~prev_q;
  assign last_cycle = (state == RUN) && (timer_q == gate_q - GATE_ONE);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_next[c] = cnt_q[c];
      ovf_next[c] = ovf_q[c];
      if (edge_det[c]) begin
        if (cnt_q[c] == CNT_MAX) ovf_next[c] = 1'b1;
        else                     cnt_next[c] = cnt_q[c] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      results_o      <= '0;
      overflow_o     <= '0;
      gate_q         <= '0;
      mode_q         <= 1'b0;
      timer_q        <= '0;
      ovf_q          <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            state   <= RUN;
            busy_o  <= 1'b1;
            gate_q  <= (gate_period_i == '0) ? GATE_ONE : gate_period_i;
            mode_q  <= mode_i;
            timer_q <= '0;
            ovf_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
          end
        end
        RUN: begin
          if (stop_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (last_cycle) begin
            // The edge seen on the closing cycle still belongs to this window.
            for (int c = 0; c < NUM_CH; c++)
              results_o[c*CNT_WIDTH +: CNT_WIDTH] <= cnt_next[c];
            overflow_o     <= ovf_next;
            result_valid_o <= 1'b1;
            timer_q        <= '0;
            ovf_q          <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
            if (!mode_q) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + GATE_ONE;
            ovf_q   <= ovf_next;
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_next[c];
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
